// File: rtl/mem_dma_if.sv
// mem_dma_if: bundles the job-control handshake and the data-memory bus of the
// mem_dma block-copy engine.
//   Job control : start, src_addr, dst_addr, count, size  (host -> engine)
//                 busy, done, err, sum                     (engine -> host)
//   Memory bus  : write_mem, read_mem, address, write_data (engine -> memory)
//                 out_mem                                  (memory -> engine)
// modport master is the engine's view, modport slave the host/memory view.
interface mem_dma_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] count;
    logic [1:0]       size;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      sum;
    logic [1:0]       write_mem;
    logic [2:0]       read_mem;
    logic [31:0]      address;
    logic [31:0]      write_data;
    logic [31:0]      out_mem;

    modport master (
        input  start, src_addr, dst_addr, count, size, out_mem,
        output busy, done, err, sum, write_mem, read_mem, address, write_data
    );

    modport slave (
        output start, src_addr, dst_addr, count, size, out_mem,
        input  busy, done, err, sum, write_mem, read_mem, address, write_data
    );
endinterface

// File: rtl/mem_dma.sv
// mem_dma: block-copy engine acting as a second master of the data-memory port.
// A job copies `count` units of `size` (01 word, 10 half, 11 byte) from src_addr
// to dst_addr, one unit per READ/WRITE cycle pair, strictly ascending, and
// accumulates a modulo-2^32 sum of the zero-extended units.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_dma_if.master: job control (start/src_addr/dst_addr/count/size in,
//          busy/done/err/sum out) and memory bus (write_mem/read_mem/address/
//          write_data out, out_mem in, combinational read data).
// The memory controls are registered: the FSM loads the values belonging to the
// state it is entering, so they are stable for the whole cycle in which the
// memory acts on them.
module mem_dma #(
    parameter int LEN_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    mem_dma_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pointer increment for a unit size code; the invalid code never reaches
    // READ/WRITE so its value is irrelevant.
    function automatic logic [31:0] unit_stride(input logic [1:0] sz);
        logic [31:0] st;
        case (sz)
            2'b01:   st = 32'd4;
            2'b10:   st = 32'd2;
            2'b11:   st = 32'd1;
            default: st = 32'd0;
        endcase
        return st;
    endfunction

    state_t           state_r;
    logic [31:0]      src_ptr_r;
    logic [31:0]      dst_ptr_r;
    logic [LEN_W-1:0] remaining_r;
    logic [1:0]       size_r;
    logic [31:0]      buffer_r;
    logic [31:0]      sum_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [2:0]       read_mem_r;
    logic [1:0]       write_mem_r;
    logic [31:0]      address_r;
    logic [31:0]      write_data_r;

    logic [31:0]      stride_s;
    logic [31:0]      src_next_s;
    logic [31:0]      dst_next_s;
    logic             last_unit_s;

    // Next pointer values and end-of-job detection for the WRITE step.
    always_comb begin
        stride_s    = unit_stride(size_r);
        src_next_s  = src_ptr_r + stride_s;
        dst_next_s  = dst_ptr_r + stride_s;
        last_unit_s = (remaining_r == {{(LEN_W-1){1'b0}}, 1'b1});
    end

    // Copy FSM with registered status and memory-control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            src_ptr_r    <= 32'd0;
            dst_ptr_r    <= 32'd0;
            remaining_r  <= {LEN_W{1'b0}};
            size_r       <= 2'b00;
            buffer_r     <= 32'd0;
            sum_r        <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            read_mem_r   <= 3'b000;
            write_mem_r  <= 2'b00;
            address_r    <= 32'd0;
            write_data_r <= 32'd0;
        end else begin
            // done is a single-cycle pulse; only the transitions into DONE raise it
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        src_ptr_r   <= bus.src_addr;
                        dst_ptr_r   <= bus.dst_addr;
                        remaining_r <= bus.count;
                        size_r      <= bus.size;
                        sum_r       <= 32'd0;
                        busy_r      <= 1'b1;
                        if (bus.size == 2'b00) begin
                            err_r   <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else if (bus.count == {LEN_W{1'b0}}) begin
                            err_r   <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            err_r      <= 1'b0;
                            address_r  <= bus.src_addr;
                            read_mem_r <= {1'b0, bus.size};
                            state_r    <= READ;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                READ: begin
                    // out_mem is already zero-extended by the memory for half/byte
                    buffer_r     <= bus.out_mem;
                    write_data_r <= bus.out_mem;
                    address_r    <= dst_ptr_r;
                    write_mem_r  <= size_r;
                    read_mem_r   <= 3'b000;
                    state_r      <= WRITE;
                end
                WRITE: begin
                    src_ptr_r    <= src_next_s;
                    dst_ptr_r    <= dst_next_s;
                    remaining_r  <= remaining_r - {{(LEN_W-1){1'b0}}, 1'b1};
                    sum_r        <= sum_r + buffer_r;
                    write_mem_r  <= 2'b00;
                    write_data_r <= 32'd0;
                    if (last_unit_s) begin
                        address_r <= 32'd0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        // next READ uses the advanced source pointer
                        address_r  <= src_next_s;
                        read_mem_r <= {1'b0, size_r};
                        state_r    <= READ;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r       <= 1'b0;
                    read_mem_r   <= 3'b000;
                    write_mem_r  <= 2'b00;
                    address_r    <= 32'd0;
                    write_data_r <= 32'd0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
    assign bus.sum        = sum_r;
    assign bus.read_mem   = read_mem_r;
    assign bus.write_mem  = write_mem_r;
    assign bus.address    = address_r;
    assign bus.write_data = write_data_r;

endmodule
